// File: rtl/ped_request_cond.sv
// Pedestrian request conditioner: synchronizes and debounces the raw crosswalk
// button, latches one request until the light FSM acknowledges it, then holds
// off further requests for a fixed window.
module ped_request_cond #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 32,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             ack,
    output logic             req,
    output logic             btn_level,
    output logic             holdoff,
    output logic [CNT_W-1:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_btn;
    logic [7:0]             deb_cnt_q, deb_cnt_d;
    logic                   btn_level_q, btn_level_d;
    logic                   press;
    state_e                 state_q, state_d;
    logic [15:0]            hold_cnt_q, hold_cnt_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;

    // Plain shift-register synchronizer; the last stage is the only tap.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end

    assign s_btn = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles the synchronized level differs from
    // the accepted level; any agreement discards the partial count.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        deb_cnt_d   = '0;
        btn_level_d = btn_level_q;
        if (s_btn != btn_level_q) begin
            if (deb_cnt_q == DEB_LAST) btn_level_d = ~btn_level_q;
            else                       deb_cnt_d   = deb_cnt_q + 8'd1;
        end
    end

    // Press is taken from the next level so req can rise on the same edge
    // as btn_level.
    assign press = btn_level_d & ~btn_level_q;

    // Request FSM next state, hold-off timer and saturating press counter.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        press_cnt_d = press_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PENDING;
                    if (press_cnt_q != '1) press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            ST_PENDING: begin
                if (ack) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == '0) state_d    = ST_IDLE;
                else                  hold_cnt_d = hold_cnt_q - 16'd1;
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
        req_d = (state_d == ST_PENDING);
    end

    // State, debounce and output registers.
    // NOTE: reset clears every flop asynchronously, including counters, so a
    // button held through reset must re-earn its full debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q   <= '0;
            btn_level_q <= 1'b0;
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            req_q       <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            btn_level_q <= btn_level_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            req_q       <= req_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign req       = req_q;
    assign btn_level = btn_level_q;
    assign holdoff   = (state_q == ST_HOLDOFF);
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ped_request_cond.sv
// Bench for ped_request_cond: a per-edge reference model pushes expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// Two instances share stimulus (default counter width and a 2-bit counter).
module tb_ped_request_cond;

    localparam int S = 2;
    localparam int D = 16;
    localparam int H = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       ack = 1'b0;
    logic       req_a, level_a, hold_a;
    logic [7:0] cnt_a;
    logic       req_b, level_b, hold_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    always #5 clk = ~clk;

    ped_request_cond dut_a (
        .clk(clk), .rst(rst), .btn(btn), .ack(ack),
        .req(req_a), .btn_level(level_a), .holdoff(hold_a), .press_cnt(cnt_a)
    );

    ped_request_cond #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .btn(btn), .ack(ack),
        .req(req_b), .btn_level(level_b), .holdoff(hold_b), .press_cnt(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       req;
        logic       level;
        logic       hold;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t exp_q[$];
    bit   bhist[$];   // raw btn as sampled at each edge since reset
    bit   shist[$];   // synchronized level used at each edge
    bit   m_level;
    bit   m_pend;
    int   m_hold;     // hold-off cycles still to run
    int   m_cnt;      // accepted presses, unbounded

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bhist.delete(); shist.delete(); exp_q.delete();
            m_level = 0; m_pend = 0; m_hold = 0; m_cnt = 0;
        end else begin
            bit   s, press, all_diff;
            exp_t e;
            s = (bhist.size() >= S) ? bhist[bhist.size()-S] : 1'b0;
            bhist.push_back(btn);
            shist.push_back(s);
            if (bhist.size() > 64) void'(bhist.pop_front());
            if (shist.size() > 64) void'(shist.pop_front());
            // Accept a new level once the last D synchronized samples all differ.
            press = 0;
            if (shist.size() >= D) begin
                all_diff = 1;
                for (int i = 0; i < D; i++)
                    if (shist[shist.size()-1-i] == m_level) all_diff = 0;
                if (all_diff) begin
                    m_level = ~m_level;
                    press   = m_level;
                end
            end
            if (m_hold > 0) m_hold--;
            else if (m_pend) begin
                if (ack) begin m_pend = 0; m_hold = H; end
            end else if (press) begin
                m_pend = 1;
                m_cnt++;
            end
            e.req   = m_pend;
            e.level = m_level;
            e.hold  = (m_hold > 0);
            e.cnt8  = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
            e.cnt2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{req: req_a, level: level_a, hold: hold_a, cnt8: cnt_a, cnt2: cnt_b};
            pops++;
            check("outputs{req,lvl,hold,cnt8,cnt2}", 32'(a), 32'(e));
            check("twin{req,lvl,hold}", {29'd0, req_b, level_b, hold_b}, {29'd0, e.req, e.level, e.hold});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        int lat;
        // Reset with the button already held.
        btn = 1'b1;
        cyc(3);
        #1;
        check("reset_state", {req_a, level_a, hold_a, cnt_a, cnt_b}, 13'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(25);
        check("held_through_reset_req", {31'd0, req_a}, 32'd1);

        // Second press while pending merges; then ack into hold-off.
        btn = 1'b0; cyc(25);
        btn = 1'b1; cyc(25);
        btn = 1'b0; cyc(25);
        pulse_ack(); cyc(40);

        // Bounce 1/0 every 5 cycles, then settle high and time the level.
        for (int i = 0; i < 6; i++) begin
            btn = 1'b1; cyc(5);
            btn = 1'b0; cyc(5);
        end
        btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (level_a) begin lat = i; break; end
        end
        check("bounce_latency_edges", lat, S + D);
        @(negedge clk);
        btn = 1'b0; cyc(25);

        // Press completing on the last hold-off edge is ignored.
        pulse_ack(); cyc(14);
        btn = 1'b1; cyc(25);
        btn = 1'b0; cyc(25);

        // Press completing one edge after hold-off ends is accepted.
        btn = 1'b1; cyc(25);
        btn = 1'b0; cyc(25);
        pulse_ack(); cyc(15);
        btn = 1'b1; cyc(25);
        btn = 1'b0; cyc(25);

        // Press and ack on the same edge in IDLE, then ack alone in IDLE.
        pulse_ack(); cyc(40);
        btn = 1'b1; cyc(17);
        pulse_ack(); cyc(10);
        btn = 1'b0; cyc(25);
        pulse_ack(); cyc(40);
        pulse_ack(); cyc(5);

        // Several full press/ack/hold-off rounds to saturate the narrow counter.
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1; cyc(25);
            btn = 1'b0; cyc(25);
            pulse_ack(); cyc(40);
        end

        // Asynchronous reset while pending.
        btn = 1'b1; cyc(25);
        @(posedge clk); #2;
        check("pending_before_reset", {31'd0, req_a}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_clears", {req_a, cnt_a, req_b, cnt_b, level_a, hold_a}, 14'd0);
        cyc(3);
        rst = 1'b0;

        // Randomized stretches of button level with sporadic ack pulses.
        for (int seg = 0; seg < 70; seg++) begin
            int len;
            btn = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                ack = ($urandom_range(0, 5) == 0);
                @(negedge clk);
            end
            ack = 1'b0;
        end
        cyc(3);
        check("scoreboard_active", {31'd0, pops > 1000}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ped_request_cond.md
Name: ped_request_cond

Overview:
- Upstream stage of the pedestrian traffic-light FSM. Conditions the raw asynchronous crosswalk button into the single-bit request that drives the FSM's pedestrian input.
- Synchronizes and debounces the button, then latches one request until the FSM acknowledges it.
- After an acknowledge, enforces a hold-off window so one crossing cannot be re-requested immediately.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn (legal 2..4).
- DEBOUNCE_CYCLES, 16, consecutive cycles a new synchronized level must persist before it is accepted (legal 1..255).
- HOLDOFF_CYCLES, 32, cycles after ack during which presses are ignored (legal 1..65535).
- CNT_W, 8, width of the accepted-press counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; all flops cleared while high.
- btn  input  1  raw pedestrian button, asynchronous to clk, bouncy, 1 = pressed.
- ack  input  1  one-cycle pulse from the light FSM when it enters the pedestrian-crossing state.
- req  output  1  registered latched request; connects to the FSM's pedestrian input.
- btn_level  output  1  debounced button level, registered.
- holdoff  output  1  high while in HOLDOFF state.
- press_cnt  output  CNT_W  saturating count of accepted presses.

Behaviour:
- Reset values: all synchronizer flops 0, debounce counter 0, btn_level 0, req 0, holdoff 0, press_cnt 0, FSM in IDLE. Deassertion of rst takes effect at the next clk edge.
- Synchronizer: btn passes through SYNC_STAGES flops; the last stage is s_btn. No logic sits between stages.
- Debounce:
  - If s_btn equals btn_level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still different, btn_level toggles on that edge and the counter clears.
  - Any return of s_btn to btn_level before then clears the counter; no partial credit is kept.
- Press event: a one-cycle internal pulse when btn_level goes 0 to 1. Releases generate no event.
- Request FSM (states IDLE, PENDING, HOLDOFF):
  - IDLE: req=0. A press moves to PENDING and sets req=1 on the same edge. ack is ignored here. Press and ack in the same cycle still moves to PENDING.
  - PENDING: req=1. Further presses merge (no effect, not counted). ack moves to IDLE-bound hold-off: state becomes HOLDOFF, req=0, and the hold-off counter loads HOLDOFF_CYCLES-1, all on the same edge.
  - HOLDOFF: req=0, holdoff=1. The counter decrements each cycle. Presses are ignored and not counted. ack is ignored. When the counter is 0, the next edge moves to IDLE. HOLDOFF therefore lasts exactly HOLDOFF_CYCLES cycles.
- press_cnt increments by 1 only on an IDLE-to-PENDING transition and saturates at 2^CNT_W-1 (no wrap).
- Latency: a clean btn rising edge that meets setup before edge k gives req=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. This is SYNC_STAGES+DEBOUNCE_CYCLES edges total, with +1 edge uncertainty for asynchronous sampling.
- Invalid or unreachable FSM encodings recover to IDLE on the next edge with req=0.
- rst asserted mid-operation (any state, mid-debounce, or mid-holdoff) immediately clears everything. A button held through reset release must again satisfy the full debounce before it generates a press.

Test Plan:
- Reset with btn=1 held, release rst: req=0 until SYNC_STAGES+DEBOUNCE_CYCLES edges after release, then req=1 and press_cnt=1.
- Defaults; btn bounces 1/0 every 5 cycles for 60 cycles, then stays 1: btn_level and req rise exactly 18 edges after the final 0-to-1 transition; press_cnt=1.
- req=1, second press (release and re-press, each debounced), then ack pulse: press_cnt stays 1; req falls on the ack edge; holdoff is high for exactly 32 cycles, then IDLE.
- Press debounced during HOLDOFF: req stays 0 and press_cnt is unchanged. A press 1 cycle after holdoff falls sets req=1.
- Debounced press edge coincides with ack in IDLE: req=1 next edge and state is PENDING. ack alone in IDLE leaves req=0.
- CNT_W=2, five full press/ack/holdoff cycles: press_cnt reads 1, 2, 3, 3, 3. Assert rst during PENDING: req and press_cnt drop to 0 without waiting for clk.
